// File: rtl/serial_comp_pkg.sv
// Shared types for the serial magnitude comparator.
//   state_t       : FSM states IDLE / RUN / DONE
//   result_t      : 2-bit running/final relation (EQ, GT, LT)
//   res_to_onehot : maps result_t to the one-hot {gt, eq, lt} output triple
package serial_comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ = 2'b00,
        RES_GT = 2'b01,
        RES_LT = 2'b10
    } result_t;

    // {gt, eq, lt}; any non-GT/LT code reads as equal
    function automatic logic [2:0] res_to_onehot(input result_t r);
        case (r)
            RES_GT:  return 3'b100;
            RES_LT:  return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

endpackage

// File: rtl/slice_decode.sv
// Combinational decode of one 2-bit comparator slice result.
// Optional feature macro: ONEHOT_CHECK_EN
//   defined   : non-one-hot {gt,eq,lt} flags illegal and decodes as EQ
//   undefined : priority gt > lt > eq, all-zero decodes as EQ, illegal tied 0
// Ports:
//   in_gt, in_eq, in_lt : slice relation flags
//   res                 : decoded slice relation
//   illegal             : slice flags are not exactly one-hot (check builds only)
module slice_decode
    import serial_comp_pkg::*;
(
    input  logic    in_gt,
    input  logic    in_eq,
    input  logic    in_lt,
    output result_t res,
    output logic    illegal
);

`ifdef ONEHOT_CHECK_EN
    always_comb begin
        res     = RES_EQ;
        illegal = 1'b0;
        case ({in_gt, in_eq, in_lt})
            3'b100:  res = RES_GT;
            3'b010:  res = RES_EQ;
            3'b001:  res = RES_LT;
            default: illegal = 1'b1;
        endcase
    end
`else
    always_comb begin
        res     = RES_EQ;
        illegal = 1'b0;
        if (in_gt)
            res = RES_GT;
        else if (in_lt)
            res = RES_LT;
        else if (in_eq)
            res = RES_EQ;
        else
            res = RES_EQ;   // all-zero slice counts as equal
    end
`endif

endmodule

// File: rtl/serial_mag_comp.sv
// Serial magnitude comparator: consumes NUM_SLICES 2-bit slice results,
// MSB slice first, and presents one registered final relation per comparison.
// Optional feature macro: ONEHOT_CHECK_EN (one-hot legality check, sticky err).
// Ports:
//   clk, rst                 : clock, async active-high reset
//   start                    : begin a comparison (honoured in IDLE only)
//   in_valid/in_ready        : slice handshake; in_gt/in_eq/in_lt slice flags
//   out_valid/out_ready      : result handshake; out_gt/out_eq/out_lt result
//   busy                     : high in RUN and DONE
//   err                      : illegal slice seen in the current comparison
module serial_mag_comp
    import serial_comp_pkg::*;
#(
    parameter int unsigned NUM_SLICES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_valid,
    input  logic in_gt,
    input  logic in_eq,
    input  logic in_lt,
    output logic in_ready,
    output logic out_valid,
    input  logic out_ready,
    output logic out_gt,
    output logic out_eq,
    output logic out_lt,
    output logic busy,
    output logic err
);

    localparam int unsigned CNT_W = $clog2(NUM_SLICES + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             decided;
    result_t          result;

    result_t          slice_res;
    logic             slice_illegal;
    logic             take;
    result_t          res_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    slice_decode u_slice_decode (
        .in_gt   (in_gt),
        .in_eq   (in_eq),
        .in_lt   (in_lt),
        .res     (slice_res),
        .illegal (slice_illegal)
    );

    // First non-equal slice (MSB first) decides; later slices only advance the count
    always_comb begin
        take    = !decided && (slice_res != RES_EQ);
        res_nxt = take ? slice_res : result;
        cnt_nxt = cnt + CNT_W'(1);
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            decided   <= 1'b0;
            result    <= RES_EQ;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_gt    <= 1'b0;
            out_eq    <= 1'b0;
            out_lt    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        cnt      <= '0;
                        decided  <= 1'b0;
                        err      <= 1'b0;
                        result   <= RES_EQ;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (in_valid && in_ready) begin
                        cnt     <= cnt_nxt;
                        result  <= res_nxt;
                        decided <= decided | take;
                        err     <= err | slice_illegal;
                        if (cnt_nxt == CNT_W'(NUM_SLICES)) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            {out_gt, out_eq, out_lt} <= res_to_onehot(res_nxt);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_gt    <= 1'b0;
                        out_eq    <= 1'b0;
                        out_lt    <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed self-checking bench for serial_mag_comp (NUM_SLICES = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_mag_comp;

    logic clk = 1'b0;
    logic rst;
    logic start, in_valid, in_gt, in_eq, in_lt, out_ready;
    logic in_ready, out_valid, out_gt, out_eq, out_lt, busy, err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_mag_comp #(.NUM_SLICES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_gt     (in_gt),
        .in_eq     (in_eq),
        .in_lt     (in_lt),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gt    (out_gt),
        .out_eq    (out_eq),
        .out_lt    (out_lt),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // {out_valid, out_gt, out_eq, out_lt, err}
    function automatic logic [7:0] res_vec();
        return {3'b000, out_valid, out_gt, out_eq, out_lt, err};
    endfunction

    // {in_ready, busy, out_valid}
    function automatic logic [7:0] ctl_vec();
        return {5'b00000, in_ready, busy, out_valid};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic slice(input logic [2:0] f);
        in_valid = 1'b1;
        {in_gt, in_eq, in_lt} = f;
        tick();
        in_valid = 1'b0;
        {in_gt, in_eq, in_lt} = 3'b000;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        {in_gt, in_eq, in_lt} = 3'b000;
        tick(); tick();
        check("reset_ctl", ctl_vec(), 8'b000);
        check("reset_res", res_vec(), 8'b00000);
        rst = 1'b0;
        tick();

        // B4 vs B1: eq, eq, gt, lt -> GT, result five cycles after start
        do_start();
        check("t1_running", ctl_vec(), 8'b110);
        slice(EQ); slice(EQ); slice(GT);
        check("t1_not_yet", ctl_vec(), 8'b110);
        slice(LT);
        check("t1_result", res_vec(), 8'b11000);
        check("t1_done_ctl", ctl_vec(), 8'b011);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_idle_ctl", ctl_vec(), 8'b000);
        check("t1_idle_res", res_vec(), 8'b00000);

        // 3F vs C0: lt then gt slices ignored
        do_start();
        slice(LT); slice(GT); slice(GT); slice(GT);
        check("t2_result", res_vec(), 8'b10010);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 5A vs 5A with a two-cycle stall between slices 2 and 3
        do_start();
        slice(EQ); slice(EQ);
        tick(); tick();
        check("t3_stall_ctl", ctl_vec(), 8'b110);
        slice(EQ);
        check("t3_before_last", ctl_vec(), 8'b110);
        slice(EQ);
        check("t3_result", res_vec(), 8'b10100);

        // hold in DONE with out_ready low while start pulses
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            tick();
            check("t4_hold_res", res_vec(), 8'b10100);
            check("t4_hold_ctl", ctl_vec(), 8'b011);
        end
        // start together with out_ready: start dropped
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        check("t4_release", ctl_vec(), 8'b000);
        tick();
        check("t4_start_dropped", ctl_vec(), 8'b000);

        // async reset after two decisive slices, then clean eq run
        do_start();
        slice(GT); slice(GT);
        #3 rst = 1'b1;
        #1;
        check("t5_async_rst", ctl_vec(), 8'b000);
        tick();
        rst = 1'b0;
        tick();
        check("t5_after_rst", ctl_vec(), 8'b000);
        do_start();
        slice(EQ); slice(EQ); slice(EQ); slice(EQ);
        check("t5_result", res_vec(), 8'b10100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // slice 2 carries gt and lt together
        do_start();
        slice(EQ); slice(3'b101); slice(EQ); slice(EQ);
`ifdef ONEHOT_CHECK_EN
        check("t6_illegal", res_vec(), 8'b10101);
`else
        check("t6_priority", res_vec(), 8'b11000);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t6_idle", ctl_vec(), 8'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
Sequential consumer of per-slice 2-bit comparator results (gt/eq/lt per digit pair). It accepts one slice result per handshake, MSB slice first, and resolves the magnitude relation of two NUM_SLICES×2-bit operands. It sits directly downstream of the 2-bit comparator slice and presents one registered final result per comparison.

Parameters:
NUM_SLICES, 4, number of 2-bit slices per operand (4 → 8-bit compare); legal range 1..16
CNT_W, $clog2(NUM_SLICES+1), slice counter width (derived localparam, not overridable)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a new comparison; honoured only in IDLE
in_valid  input  1  slice result present on in_gt/in_eq/in_lt
in_gt  input  1  slice A-digit > B-digit
in_eq  input  1  slice A-digit == B-digit
in_lt  input  1  slice A-digit < B-digit
in_ready  output  1  block accepts a slice this cycle
out_valid  output  1  final result valid
out_ready  input  1  downstream accepts the result
out_gt  output  1  operand A > operand B
out_eq  output  1  operand A == operand B
out_lt  output  1  operand A < operand B
busy  output  1  high in RUN and DONE
err  output  1  illegal slice input seen in the current comparison (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high on rst. All state is updated on the rising edge of clk.
- Reset (asynchronous, any state): state=IDLE; counter=0; decided=0; result=EQ; outputs in_ready, out_valid, out_gt, out_lt, busy and err =0; out_eq=0, masked by out_valid.
- Result outputs are registered and qualified: out_gt/out_eq/out_lt are driven only while out_valid=1 and read 0 otherwise.
- FSM, states IDLE, RUN, DONE:
  - IDLE: in_ready=0. start=1 → RUN next cycle; clear counter, decided and err; set result=EQ.
  - RUN: in_ready=1. A slice is accepted on in_valid & in_ready.
    - Per accepted slice, if decided=0: gt → result=GT, decided=1; lt → result=LT, decided=1; eq → no change.
    - If decided=1, slices are still consumed but ignored. This gives a fixed NUM_SLICES cadence and no early exit.
    - The counter increments on each accept. The accept that makes counter=NUM_SLICES → DONE.
    - in_valid=0 cycles are stalls: no state change and no timeout.
  - DONE: in_ready=0; out_valid=1, with exactly one of out_gt/out_eq/out_lt set and held stable. out_valid & out_ready → IDLE next cycle.
- Latency: out_valid rises the cycle after the last slice is accepted. Minimum start-to-result time is NUM_SLICES+1 cycles; back-to-back minimum period is NUM_SLICES+2 cycles.
- start in RUN or DONE is ignored. start and out_ready together in DONE: the block returns to IDLE and start is dropped.
- NUM_SLICES=1: the first accept goes straight to DONE.
- The counter never wraps: comparison at ==NUM_SLICES, CNT_W sized to hold NUM_SLICES.

Optional Feature:
Macro ONEHOT_CHECK_EN.
- Defined:
  - A slice is illegal if {in_gt,in_eq,in_lt} is not exactly one-hot.
  - An illegal accepted slice sets err, which stays sticky until the next honoured start.
  - An illegal slice is treated as eq: the decision is unchanged.
  - err stays visible through DONE.
- Undefined:
  - No check; err is tied to 0.
  - Decode priority is gt > lt > eq, and all-zero is treated as eq.

Decomposition:
- Package serial_comp_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - 2-bit result_t with constants RES_EQ=2'b00, RES_GT=2'b01, RES_LT=2'b10.
  - Function to map result_t to the one-hot {gt,eq,lt}.
- One sub-module, slice_decode (combinational): maps {in_gt,in_eq,in_lt} to result_t plus an illegal flag, with priority and legality per the ONEHOT_CHECK_EN rules. The FSM and counter stay in the top module.

Test Plan:
- A=8'hB4, B=8'hB1; slices (MSB first) eq, eq, gt, lt; start then in_valid every cycle → out_valid 5 cycles after start, out_gt=1, out_eq=0, out_lt=0, err=0.
- A=8'h3F, B=8'hC0; slices lt, gt, gt, gt → out_lt=1; the later gt slices are ignored.
- A=B=8'h5A; four eq slices with in_valid low for 2 cycles between slices 2 and 3 → out_eq=1, and out_valid is delayed by exactly 2 cycles.
- Hold out_ready=0 for 3 cycles in DONE while pulsing start → out_valid and the result stay stable and start is ignored. out_ready=1 → IDLE on the next cycle with out_valid=0.
- Assert rst asynchronously (mid-cycle) after 2 accepted slices → in_ready, busy and out_valid go to 0 immediately. A new start and 4 eq slices then give out_eq=1 with no residue from the aborted run.
- With ONEHOT_CHECK_EN: slice 2 = {gt=1,lt=1}, others eq → err=1 and out_eq=1. Without the macro, the same stimulus gives err=0 and out_gt=1.
